// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// datapath width and default busy lengths.
package md_pkg;

  localparam int MD_W            = 32;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result generator: signed/unsigned 64-bit product and
// quotient/remainder, including the overflow and zero-divisor cases.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]      md_op,
  input  logic [MD_W-1:0] a,
  input  logic [MD_W-1:0] b,
  output logic [MD_W-1:0] hi_res,
  output logic [MD_W-1:0] lo_res,
  output logic            div0
);

  logic [2*MD_W-1:0] ext_a, ext_b, prod_s, prod_u;
  logic              signed_div, q_neg, r_neg;
  logic [MD_W-1:0]   mag_a, mag_b, q_u, r_u, quot, rem;

  always_comb begin
    ext_a  = {{MD_W{a[MD_W-1]}}, a};
    ext_b  = {{MD_W{b[MD_W-1]}}, b};
    prod_s = ext_a * ext_b;
    prod_u = {{MD_W{1'b0}}, a} * {{MD_W{1'b0}}, b};

    // Signed division works on magnitudes; 0x80000000 / -1 falls out as
    // magnitude 0x80000000 with a positive sign, i.e. LO = 0x80000000, HI = 0.
    signed_div = (md_op == MD_DIV);
    mag_a      = (signed_div && a[MD_W-1]) ? -a : a;
    mag_b      = (signed_div && b[MD_W-1]) ? -b : b;
    div0       = md_is_div(md_op) && (b == '0);
    q_u        = '0;
    r_u        = '0;
    if (b != '0) begin
      q_u = mag_a / mag_b;
      r_u = mag_a % mag_b;
    end
    q_neg = signed_div && (a[MD_W-1] ^ b[MD_W-1]);
    r_neg = signed_div && a[MD_W-1];
    quot  = q_neg ? -q_u : q_u;
    rem   = r_neg ? -r_u : r_u;

    hi_res = '0;
    lo_res = '0;
    case (md_op)
      MD_MULT:         {hi_res, lo_res} = prod_s;
      MD_MULTU:        {hi_res, lo_res} = prod_u;
      MD_DIV, MD_DIVU: begin
        hi_res = rem;
        lo_res = quot;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency pending commit
// and the combinational stall_md request for the hazard logic.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      md_op,
  input  logic [MD_W-1:0] a,
  input  logic [MD_W-1:0] b,
  input  logic            md_use_D,
  input  logic            rd_sel,
  output logic [MD_W-1:0] rd_data,
  output logic            busy,
  output logic            stall_md
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [MD_W-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [MD_W-1:0]  pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_div0_q, pend_div0_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [MD_W-1:0]  hi_res, lo_res;
  logic             div0;
  logic             start_arith, accept, commit;

  md_arith u_arith (
    .md_op  (md_op),
    .a      (a),
    .b      (b),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .div0   (div0)
  );

  assign start_arith = start && (md_op <= 3'd3);
  assign busy        = (cnt_q != '0);
  assign accept      = start_arith && !busy;
  assign commit      = busy && (cnt_q == CNT_W'(1));
  assign stall_md    = md_use_D && (start_arith || busy);
  assign rd_data     = rd_sel ? lo_q : hi_q;

  always_comb begin
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_div0_d = pend_div0_q;
    cnt_d       = cnt_q;

    // A start while busy is dropped: no reload, no new pending result.
    if (accept) begin
      pend_hi_d   = hi_res;
      pend_lo_d   = lo_res;
      pend_div0_d = div0;
      cnt_d       = md_is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    if (commit && !pend_div0_q) begin
      hi_d = pend_hi_q;
      lo_d = pend_lo_q;
    end

    // mthi/mtlo is the younger instruction, so it wins over a same-edge commit.
    if (start && (md_op == MD_MTHI)) hi_d = a;
    if (start && (md_op == MD_MTLO)) lo_d = a;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q        <= '0;
      lo_q        <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_div0_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_div0_q <= pend_div0_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed spec cases plus randomized ops against a
// 64-bit arithmetic reference model of committed HI/LO.
module tb_md_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        md_use_D = 1'b0;
  logic        rd_sel = 1'b0;
  logic [31:0] rd_data;
  logic        busy, stall_md;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  md_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
    .md_use_D(md_use_D), .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy),
    .stall_md(stall_md)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: 64-bit arithmetic; divide by zero leaves committed values.
  function automatic void ref_md(input logic [2:0] op, input logic [31:0] x, y,
                                 output logic [31:0] h, output logic [31:0] l);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    h = exp_hi;
    l = exp_lo;
    case (op)
      3'd0: begin p = longint'(sx * sy); h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = ux * uy; h = p[63:32]; l = p[31:0]; end
      3'd2: if (y != 0) begin
        sq = sx / sy; sr = sx % sy;
        h = sr[31:0]; l = sq[31:0];
      end
      3'd3: if (y != 0) begin
        p = ux / uy; h = p[31:0];
        h = 32'((ux % uy));
        l = p[31:0];
      end
      default: ;
    endcase
  endfunction

  task automatic check_hilo(input string name);
    rd_sel = 1'b0; #1;
    n_cmp++;
    if (rd_data !== exp_hi) begin
      n_err++; $display("FAIL %s HI: got %h expected %h", name, rd_data, exp_hi);
    end
    rd_sel = 1'b1; #1;
    n_cmp++;
    if (rd_data !== exp_lo) begin
      n_err++; $display("FAIL %s LO: got %h expected %h", name, rd_data, exp_lo);
    end
    rd_sel = 1'b0;
  endtask

  // Issue an arithmetic op, check busy length and that HI is frozen until commit.
  task automatic run_arith(input logic [2:0] op, input logic [31:0] av, bv,
                           input logic [31:0] eh, el, input string name);
    int n, cnt;
    n = (op >= 3'd2) ? DIV_CYCLES : MULT_CYCLES;
    start = 1'b1; md_op = op; a = av; b = bv; rd_sel = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 64) begin
      n_cmp++;
      if (rd_data !== exp_hi) begin
        n_err++; $display("FAIL %s early_hi: got %h expected %h", name, rd_data, exp_hi);
      end
      cnt++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (cnt != n) begin
      n_err++; $display("FAIL %s busy_len: got %0d expected %0d", name, cnt, n);
    end
    exp_hi = eh; exp_lo = el;
    check_hilo(name);
  endtask

  task automatic test_reset;
    reset = 1'b1; md_use_D = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_cmp++;
    if (stall_md !== 1'b0) begin n_err++; $display("FAIL reset stall: got %b expected 0", stall_md); end
    md_use_D = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check_hilo("reset");
  endtask

  task automatic test_directed;
    @(posedge clk); #1;
    run_arith(3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg");
    run_arith(3'd1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, "multu");
    run_arith(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    run_arith(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "div_ovf");
  endtask

  task automatic test_mt_and_div0;
    start = 1'b1; md_op = 3'd4; a = 32'h11; md_use_D = 1'b1; #1;
    n_cmp++;
    if (stall_md !== 1'b0) begin n_err++; $display("FAIL mt_stall: got %b expected 0", stall_md); end
    @(posedge clk); #1;
    md_op = 3'd5; a = 32'h22; md_use_D = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL mt_busy: got %b expected 0", busy); end
    exp_hi = 32'h11; exp_lo = 32'h22;
    check_hilo("mthi_mtlo");
    run_arith(3'd3, 32'd5, 32'd0, 32'h11, 32'h22, "divu_zero");
    start = 1'b1; md_op = 3'd4; a = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (stall_md !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mthi_idle: got stall=%b busy=%b expected 0/0", stall_md, busy);
    end
    exp_hi = 32'hDEADBEEF;
    check_hilo("mthi_dead");
  endtask

  task automatic test_stall;
    int cnt;
    logic [31:0] h, l;
    for (int pass = 0; pass < 2; pass++) begin
      md_use_D = (pass == 0);
      start = 1'b1; md_op = 3'd0; a = 32'd6; b = 32'd7; #1;
      n_cmp++;
      if (stall_md !== md_use_D) begin
        n_err++; $display("FAIL stall_t0: got %b expected %b", stall_md, md_use_D);
      end
      @(posedge clk); #1;
      start = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 64) begin
        n_cmp++;
        if (stall_md !== md_use_D) begin
          n_err++; $display("FAIL stall_busy: got %b expected %b", stall_md, md_use_D);
        end
        cnt++;
        @(posedge clk); #1;
      end
      n_cmp++;
      if (stall_md !== 1'b0 || cnt != MULT_CYCLES) begin
        n_err++; $display("FAIL stall_end: got stall=%b len=%0d expected 0/%0d", stall_md, cnt, MULT_CYCLES);
      end
      ref_md(3'd0, 32'd6, 32'd7, h, l);
      exp_hi = h; exp_lo = l;
      check_hilo("stall_mult");
    end
    md_use_D = 1'b0;
  endtask

  task automatic test_hazard;
    int cnt;
    // mthi while busy: visible now, then overwritten by the commit.
    start = 1'b1; md_op = 3'd0; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    md_op = 3'd4; a = 32'h0000AAAA;
    @(posedge clk); #1;
    start = 1'b0; rd_sel = 1'b0; #1;
    n_cmp++;
    if (rd_data !== 32'h0000AAAA || busy !== 1'b1) begin
      n_err++; $display("FAIL mthi_busy: got %h busy=%b expected 0000aaaa busy=1", rd_data, busy);
    end
    cnt = 0;
    while (busy === 1'b1 && cnt < 64) begin cnt++; @(posedge clk); #1; end
    exp_hi = 32'd0; exp_lo = 32'd12;
    check_hilo("mthi_then_commit");
    // Second start while busy must not reload or change the result.
    start = 1'b1; md_op = 3'd2; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 64) begin
      if (cnt == 2) begin start = 1'b1; md_op = 3'd0; a = 32'd9; b = 32'd9; end
      else start = 1'b0;
      cnt++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_cmp++;
    if (cnt != DIV_CYCLES) begin
      n_err++; $display("FAIL ignore_start len: got %0d expected %0d", cnt, DIV_CYCLES);
    end
    exp_hi = 32'd2; exp_lo = 32'd14;
    check_hilo("ignore_start");
  endtask

  task automatic test_reset_mid_div;
    start = 1'b1; md_op = 3'd3; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1; #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL async_reset busy: got %b expected 0", busy); end
    exp_hi = '0; exp_lo = '0;
    check_hilo("async_reset");
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL no_commit busy: got %b expected 0", busy); end
    check_hilo("no_commit");
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] x, y, h, l;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (op <= 3'd3) begin
        ref_md(op, x, y, h, l);
        run_arith(op, x, y, h, l, "random_arith");
      end else begin
        start = 1'b1; md_op = op; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        if (op == 3'd4) exp_hi = x;
        if (op == 3'd5) exp_lo = x;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL random_mt busy: got %b expected 0", busy); end
        check_hilo("random_mt");
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mt_and_div0();
    test_stall();
    test_hazard();
    test_reset_mid_div();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
